// File: rtl/z_ins_encoder.sv
// MIPS instruction-word encoder: field requests in, registered encode into a small FIFO,
// words out tagged with a word address. Optional checksum built when ENC_CHKSUM_EN is defined.
module z_ins_encoder #(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned ADDR_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        fmt,
  input  logic [5:0]        opcode,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [4:0]        shamt,
  input  logic [5:0]        funct,
  input  logic [15:0]       imm,
  input  logic [25:0]       target,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_word,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err_illegal,
  output logic [7:0]        err_cnt,
  output logic [31:0]       chk
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthC = CntW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    FmtR   = 2'b00,
    FmtI   = 2'b01,
    FmtJ   = 2'b10,
    FmtIll = 2'b11
  } fmt_e;

  logic [31:0]       mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              in_ready_q;
  logic [ADDR_W-1:0] addr_q;
  logic              err_ill_q;
  logic [7:0]        err_cnt_q;

  logic        accept, push, pop, illegal;
  logic [31:0] enc_word;

  assign accept  = in_valid && in_ready_q;
  assign illegal = accept && (fmt_e'(fmt) == FmtIll);
  assign push    = accept && (fmt_e'(fmt) != FmtIll);
  assign pop     = (cnt_q != '0) && out_ready;

  always_comb begin
    enc_word = '0;
    unique case (fmt_e'(fmt))
      FmtR:    enc_word = {6'b0, rs, rt, rd, shamt, funct};
      FmtI:    enc_word = {opcode, rs, rt, imm};
      FmtJ:    enc_word = {opcode, target};
      FmtIll:  enc_word = '0;
      default: enc_word = '0;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (pop && !push) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // in_ready is registered from the next count so it never depends on out_ready combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      in_ready_q <= 1'b1;
      addr_q     <= '0;
      err_ill_q  <= 1'b0;
      err_cnt_q  <= '0;
    end else if (clr) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      in_ready_q <= 1'b1;
      addr_q     <= '0;
      err_ill_q  <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= enc_word;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        addr_q   <= addr_q + 1'b1;
      end
      cnt_q      <= cnt_d;
      in_ready_q <= (cnt_d < DepthC);
      err_ill_q  <= illegal;
      if (illegal && (err_cnt_q != 8'hFF)) begin
        err_cnt_q <= err_cnt_q + 1'b1;
      end
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = (cnt_q != '0);
  assign out_word    = mem_q[rd_ptr_q];
  assign out_addr    = addr_q;
  assign err_illegal = err_ill_q;
  assign err_cnt     = err_cnt_q;

`ifdef ENC_CHKSUM_EN
  logic [31:0] chk_q;
  logic [4:0]  rot_amt;
  logic [31:0] rot_word;

  assign rot_amt  = 5'(addr_q);
  // A rotate by 0 relies on the 32-bit right shift by 32 yielding zero.
  assign rot_word = (out_word << rot_amt) | (out_word >> (6'd32 - {1'b0, rot_amt}));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_q <= '0;
    end else if (clr) begin
      chk_q <= '0;
    end else if (pop) begin
      chk_q <= chk_q ^ rot_word;
    end
  end

  assign chk = chk_q;
`else
  assign chk = 32'h0;
`endif

endmodule

// File: tb/tb_z_ins_encoder.sv
// Self-checking bench for z_ins_encoder: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_z_ins_encoder;

  localparam int DEPTH  = 2;
  localparam int ADDR_W = 8;

  logic              clk, rst_n, clr, in_valid, in_ready, out_valid, out_ready, err_illegal;
  logic [1:0]        fmt;
  logic [5:0]        opcode, funct;
  logic [4:0]        rs, rt, rd, shamt;
  logic [15:0]       imm;
  logic [25:0]       target;
  logic [31:0]       out_word, chk;
  logic [ADDR_W-1:0] out_addr;
  logic [7:0]        err_cnt;

  z_ins_encoder #(.FIFO_DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
    .imm(imm), .target(target), .out_valid(out_valid), .out_ready(out_ready),
    .out_word(out_word), .out_addr(out_addr), .err_illegal(err_illegal), .err_cnt(err_cnt),
    .chk(chk)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [31:0] mq[$];
  int          m_addr, m_err, n_pops;
  logic [31:0] m_chk;
  bit          m_ill;

  function automatic logic [31:0] exp_chk();
`ifdef ENC_CHKSUM_EN
    return m_chk;
`else
    return 32'h0;
`endif
  endfunction

  function automatic logic [31:0] rotl(input logic [31:0] w, input int n);
    return (w << n) | (w >> (32 - n));
  endfunction

  function automatic logic [31:0] ref_enc();
    longint v;
    case (fmt)
      2'd0:    v = rs * 64'd2097152 + rt * 64'd65536 + rd * 64'd2048 + shamt * 64'd64 + funct;
      2'd1:    v = opcode * 64'd67108864 + rs * 64'd2097152 + rt * 64'd65536 + imm;
      default: v = opcode * 64'd67108864 + target;
    endcase
    return v[31:0];
  endfunction

  task automatic model_reset();
    mq.delete();
    m_addr = 0;
    m_err  = 0;
    m_chk  = 32'h0;
    m_ill  = 1'b0;
    n_pops = 0;
  endtask

  task automatic set_req(input logic [1:0] f, input logic [5:0] op, input logic [4:0] s,
                         input logic [4:0] t, input logic [4:0] d, input logic [4:0] sh,
                         input logic [5:0] fn, input logic [15:0] im, input logic [25:0] tg);
    fmt = f; opcode = op; rs = s; rt = t; rd = d; shamt = sh; funct = fn; imm = im; target = tg;
  endtask

  task automatic rand_req(input bit allow_illegal);
    logic [1:0] f;
    f = 2'($urandom_range(0, 2));
    if (allow_illegal && ($urandom_range(0, 15) == 0)) f = 2'd3;
    set_req(f, 6'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
            6'($urandom), 16'($urandom), 26'($urandom));
  endtask

  // One clock of DUT and model; inputs must already be driven.
  task automatic tick();
    bit          acc, pop;
    logic [31:0] w;
    acc = in_valid && (mq.size() < DEPTH);
    pop = (mq.size() > 0) && out_ready;
    w   = ref_enc();
    @(posedge clk);
    #1;
    m_ill = 1'b0;
    if (clr) begin
      mq.delete();
      m_addr = 0;
      m_err  = 0;
      m_chk  = 32'h0;
    end else begin
      if (pop) begin
        m_chk  = m_chk ^ rotl(mq[0], m_addr % 32);
        void'(mq.pop_front());
        m_addr = (m_addr + 1) % (1 << ADDR_W);
        n_pops++;
      end
      if (acc) begin
        if (fmt == 2'd3) begin
          m_ill = 1'b1;
          if (m_err < 255) m_err++;
        end else begin
          mq.push_back(w);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_req(2'd0, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0);
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_word !== 32'h0) begin n_bad++; $display("FAIL reset_out_word: got %h want 0", out_word); end
    n_cmp++; if (out_addr !== '0) begin n_bad++; $display("FAIL reset_out_addr: got %h want 0", out_addr); end
    n_cmp++; if (err_illegal !== 1'b0) begin n_bad++; $display("FAIL reset_err_illegal: got %b want 0", err_illegal); end
    n_cmp++; if (err_cnt !== 8'h0) begin n_bad++; $display("FAIL reset_err_cnt: got %h want 0", err_cnt); end
    n_cmp++; if (chk !== 32'h0) begin n_bad++; $display("FAIL reset_chk: got %h want 0", chk); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    rst_n = 1'b1;
  endtask

  task automatic test_vectors();
    logic [31:0] cexp;
    set_req(2'd0, 6'h3F, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'hFFFF, 26'h0);
    in_valid = 1'b1; out_ready = 1'b0;
    tick();
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL vec_r_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_word !== 32'h00221820) begin n_bad++; $display("FAIL vec_r_word: got %h want 00221820", out_word); end
    n_cmp++; if (out_addr !== 8'd0) begin n_bad++; $display("FAIL vec_r_addr: got %h want 0", out_addr); end
    set_req(2'd1, 6'd4, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'h1821, 26'h0);
    out_ready = 1'b1;
    tick();
    n_cmp++; if (out_word !== 32'h10221821) begin n_bad++; $display("FAIL vec_i_word: got %h want 10221821", out_word); end
    n_cmp++; if (out_addr !== 8'd1) begin n_bad++; $display("FAIL vec_i_addr: got %h want 1", out_addr); end
    set_req(2'd2, 6'd2, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 26'h100);
    tick();
    n_cmp++; if (out_word !== 32'h08000100) begin n_bad++; $display("FAIL vec_j_word: got %h want 08000100", out_word); end
    n_cmp++; if (out_addr !== 8'd2) begin n_bad++; $display("FAIL vec_j_addr: got %h want 2", out_addr); end
`ifdef ENC_CHKSUM_EN
    cexp = 32'h20662862;
`else
    cexp = 32'h0;
`endif
    n_cmp++; if (chk !== cexp) begin n_bad++; $display("FAIL vec_chk: got %h want %h", chk, cexp); end
    in_valid = 1'b0;
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL vec_drain_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_addr !== 8'd3) begin n_bad++; $display("FAIL vec_drain_addr: got %h want 3", out_addr); end
  endtask

  task automatic test_backpressure();
    logic [31:0] first, second;
    clr = 1'b1; in_valid = 1'b0; tick(); clr = 1'b0;
    out_ready = 1'b0; in_valid = 1'b1;
    rand_req(1'b0); first = ref_enc(); tick();
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_1: got %b want 1", in_ready); end
    rand_req(1'b0); second = ref_enc(); tick();
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready_full: got %b want 0", in_ready); end
    rand_req(1'b0); tick();
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready_hold: got %b want 0", in_ready); end
    n_cmp++; if (out_word !== first) begin n_bad++; $display("FAIL bp_head_stable: got %h want %h", out_word, first); end
    in_valid = 1'b0; out_ready = 1'b1; tick();
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_after_pop: got %b want 1", in_ready); end
    n_cmp++; if (out_word !== second) begin n_bad++; $display("FAIL bp_order: got %h want %h", out_word, second); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_third_dropped: got %b want 0", out_valid); end
  endtask

  task automatic test_illegal();
    clr = 1'b1; tick(); clr = 1'b0;
    out_ready = 1'b0; in_valid = 1'b1;
    set_req(2'd3, 6'h1, 5'd1, 5'd1, 5'd1, 5'd1, 6'h1, 16'h1, 26'h1);
    tick();
    in_valid = 1'b0;
    n_cmp++; if (err_illegal !== 1'b1) begin n_bad++; $display("FAIL ill_pulse: got %b want 1", err_illegal); end
    n_cmp++; if (err_cnt !== 8'd1) begin n_bad++; $display("FAIL ill_cnt: got %0d want 1", err_cnt); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL ill_no_enqueue: got %b want 0", out_valid); end
    tick();
    n_cmp++; if (err_illegal !== 1'b0) begin n_bad++; $display("FAIL ill_pulse_end: got %b want 0", err_illegal); end
    in_valid = 1'b1;
    repeat (256) tick();
    in_valid = 1'b0;
    n_cmp++; if (err_cnt !== 8'd255) begin n_bad++; $display("FAIL ill_saturate: got %0d want 255", err_cnt); end
    n_cmp++; if (err_cnt !== 8'(m_err)) begin n_bad++; $display("FAIL ill_model: got %0d want %0d", err_cnt, m_err); end
  endtask

  task automatic test_wrap();
    int guard;
    clr = 1'b1; tick(); clr = 1'b0;
    n_pops = 0; guard = 0;
    out_ready = 1'b1; in_valid = 1'b1;
    while (n_pops < 257 && guard < 600) begin
      rand_req(1'b0);
      tick();
      guard++;
      if (n_pops == 256 || n_pops == 257) begin
        n_cmp++;
        if (out_addr !== ((n_pops == 256) ? 8'd0 : 8'd1)) begin
          n_bad++; $display("FAIL wrap_addr@%0d: got %0d want %0d", n_pops, out_addr, n_pops - 256);
        end
      end
    end
    n_cmp++; if (n_pops < 257) begin n_bad++; $display("FAIL wrap_timeout: got %0d pops want 257", n_pops); end
    in_valid = 1'b0;
  endtask

  task automatic test_clr();
    out_ready = 1'b0; in_valid = 1'b1;
    set_req(2'd3, 6'h0, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0); tick();
    rand_req(1'b0); tick();
    rand_req(1'b0); tick();
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL clr_prefull: got %b want 0", in_ready); end
    clr = 1'b1; out_ready = 1'b1; rand_req(1'b0); tick(); clr = 1'b0; in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL clr_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_addr !== 8'd0) begin n_bad++; $display("FAIL clr_addr: got %0d want 0", out_addr); end
    n_cmp++; if (err_cnt !== 8'd0) begin n_bad++; $display("FAIL clr_err_cnt: got %0d want 0", err_cnt); end
    n_cmp++; if (chk !== 32'h0) begin n_bad++; $display("FAIL clr_chk: got %h want 0", chk); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL clr_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 500; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      clr       = ($urandom_range(0, 63) == 0);
      rand_req(1'b1);
      tick();
      clr = 1'b0;
      n_cmp++; if (in_ready !== (mq.size() < DEPTH)) begin n_bad++; $display("FAIL rnd_in_ready@%0d: got %b want %b", c, in_ready, mq.size() < DEPTH); end
      n_cmp++; if (out_valid !== (mq.size() > 0)) begin n_bad++; $display("FAIL rnd_out_valid@%0d: got %b want %b", c, out_valid, mq.size() > 0); end
      if (mq.size() > 0) begin
        n_cmp++; if (out_word !== mq[0]) begin n_bad++; $display("FAIL rnd_word@%0d: got %h want %h", c, out_word, mq[0]); end
      end
      n_cmp++; if (out_addr !== 8'(m_addr)) begin n_bad++; $display("FAIL rnd_addr@%0d: got %0d want %0d", c, out_addr, m_addr); end
      n_cmp++; if (err_illegal !== m_ill) begin n_bad++; $display("FAIL rnd_err_ill@%0d: got %b want %b", c, err_illegal, m_ill); end
      n_cmp++; if (err_cnt !== 8'(m_err)) begin n_bad++; $display("FAIL rnd_err_cnt@%0d: got %0d want %0d", c, err_cnt, m_err); end
      n_cmp++; if (chk !== exp_chk()) begin n_bad++; $display("FAIL rnd_chk@%0d: got %h want %h", c, chk, exp_chk()); end
    end
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; in_valid = 1'b1;
    rand_req(1'b0); tick();
    rand_req(1'b0); tick();
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_valid: got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (out_addr !== 8'd0) begin n_bad++; $display("FAIL rstmid_addr: got %0d want 0", out_addr); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    out_ready = 1'b1;
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_no_survivor: got %b want 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_backpressure();
    test_illegal();
    test_wrap();
    test_clr();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
